// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - opcodes, FSM states and quarter-phase bus drive table for the I2C bit engine
package i2c_pkg;

    localparam logic [1:0] INST_START_TX   = 2'd0;
    localparam logic [1:0] INST_STOP_TX    = 2'd1;
    localparam logic [1:0] INST_READ_BYTE  = 2'd2;
    localparam logic [1:0] INST_WRITE_BYTE = 2'd3;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [3:0] LAST_DATA_BIT = 4'd7;
    localparam logic [3:0] ACK_BIT       = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STOP,
        ST_BIT,
        ST_DONE
    } state_t;

    // Returns {scl_oe, sda_oe} for quarter q of a primitive; bit_pull is the SDA level held through a BIT slot
    function automatic logic [1:0] quarter_drive(input state_t st, input logic [1:0] q, input logic bit_pull);
        logic [1:0] d;
        d = 2'b00;
        case (st)
            ST_START: d = (q == Q2) ? 2'b01 : ((q == Q3) ? 2'b11 : 2'b00);
            ST_STOP:  d = (q == Q0) ? 2'b11 : ((q == Q3) ? 2'b00 : 2'b01);
            ST_BIT:   d = {(q == Q0) || (q == Q3), bit_pull};
            default:  d = 2'b00;
        endcase
        return d;
    endfunction

    function automatic state_t cmd_state(input logic [1:0] inst);
        state_t st;
        case (inst)
            INST_START_TX:   st = ST_START;
            INST_STOP_TX:    st = ST_STOP;
            INST_READ_BYTE:  st = ST_BIT;
            INST_WRITE_BYTE: st = ST_BIT;
            default:         st = ST_BIT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - CLK_DIV prescaler giving a one-cycle tick at the end of each quarter plus the quarter index
module i2c_quarter_tick #(
    parameter int CLK_DIV = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       freeze,
    output logic       tick,
    output logic [1:0] quarter
);

    localparam logic [15:0] TERMINAL = 16'(CLK_DIV - 1);

    logic [15:0] count;

    assign tick = run && !freeze && (count == TERMINAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            quarter <= '0;
        end else if (!run) begin
            count   <= '0;
            quarter <= '0;
        end else if (!freeze) begin
            if (tick) begin
                count   <= '0;
                quarter <= quarter + 2'd1;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_bit_engine.sv
// rtl/i2c_bit_engine.sv - I2C master bit engine (START/STOP/READ/WRITE byte); I2C_CLK_STRETCH_EN enables slave clock stretching
module i2c_bit_engine
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] instruction,
    input  logic       enable,
    input  logic [7:0] byte_in,
    input  logic       read_ack,
    output logic       complete,
    output logic       error,
    output logic [7:0] byte_out,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    state_t     state, state_nx;
    logic       tick, run, freeze, last_quarter;
    logic [1:0] quarter;
    logic       is_write, ack_pull;
    logic [7:0] tx_byte;
    logic [6:0] rx_shift;
    logic [3:0] bit_idx;

    assign run          = (state == ST_START) || (state == ST_STOP) || (state == ST_BIT);
    assign last_quarter = tick && (quarter == Q3);
    assign complete     = (state == ST_IDLE) || (state == ST_DONE);

`ifdef I2C_CLK_STRETCH_EN
    // Hold the phase while a slave keeps SCL low after we released it
    assign freeze = ((state == ST_BIT) || (state == ST_STOP)) && ((quarter == Q1) || (quarter == Q2))
                    && !scl_oe && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign freeze        = 1'b0;
`endif

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .freeze  (freeze),
        .tick    (tick),
        .quarter (quarter)
    );

    // SDA pull level of bit slot idx: data bits MSB first, slot 8 is the ACK slot
    function automatic logic slot_pull(input logic wr, input logic [7:0] data, input logic ack,
                                       input logic [3:0] idx);
        logic [2:0] pos;
        pos = 3'd7 - idx[2:0];
        if (idx == ACK_BIT) return !wr && ack;
        return wr && !data[pos];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:           if (enable) state_nx = cmd_state(instruction);
            ST_START, ST_STOP: if (last_quarter) state_nx = ST_DONE;
            ST_BIT:            if (last_quarter && (bit_idx == ACK_BIT)) state_nx = ST_DONE;
            ST_DONE:           if (!enable) state_nx = ST_IDLE;
            default:           state_nx = ST_IDLE;
        endcase
    end

    // Pad drives are registered and loaded at each quarter boundary so they never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            error    <= 1'b0;
            byte_out <= '0;
            is_write <= 1'b0;
            ack_pull <= 1'b0;
            tx_byte  <= '0;
            rx_shift <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (enable) begin
                    is_write <= (instruction == INST_WRITE_BYTE);
                    tx_byte  <= byte_in;
                    ack_pull <= read_ack;
                    error    <= 1'b0;
                    bit_idx  <= '0;
                    {scl_oe, sda_oe} <= quarter_drive(cmd_state(instruction), Q0,
                        slot_pull(instruction == INST_WRITE_BYTE, byte_in, read_ack, 4'd0));
                end
                ST_START, ST_STOP, ST_BIT: if (tick) begin
                    if ((state == ST_BIT) && (quarter == Q1)) begin
                        if (bit_idx == ACK_BIT) begin
                            if (is_write && sda_in) error <= 1'b1;
                        end else if (!is_write) begin
                            rx_shift <= {rx_shift[5:0], sda_in};
                            if (bit_idx == LAST_DATA_BIT) byte_out <= {rx_shift, sda_in};
                        end
                    end
                    if (quarter != Q3) begin
                        {scl_oe, sda_oe} <= quarter_drive(state, quarter + 2'd1,
                            slot_pull(is_write, tx_byte, ack_pull, bit_idx));
                    end else if ((state == ST_BIT) && (bit_idx != ACK_BIT)) begin
                        bit_idx <= bit_idx + 4'd1;
                        {scl_oe, sda_oe} <= quarter_drive(ST_BIT, Q0,
                            slot_pull(is_write, tx_byte, ack_pull, bit_idx + 4'd1));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bit_engine.sv
// tb/tb_i2c_bit_engine.sv - self-checking bench for i2c_bit_engine; I2C_CLK_STRETCH_EN selects stretch expectations
module tb_i2c_bit_engine;

    localparam int D = 4;
`ifdef I2C_CLK_STRETCH_EN
    localparam int STRETCH_DELAY = 20;
`else
    localparam int STRETCH_DELAY = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] instruction;
    logic       enable;
    logic [7:0] byte_in;
    logic       read_ack;
    logic       complete, error;
    logic [7:0] byte_out;
    logic       scl_oe, sda_oe, scl_in, sda_in;
    logic       slave_pull = 1'b0;
    logic       scl_stretch = 1'b0;

    always #5 clk = ~clk;

    assign scl_in = ~scl_oe & ~scl_stretch;
    assign sda_in = ~sda_oe & ~slave_pull;

    i2c_bit_engine #(.CLK_DIV(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .enable      (enable),
        .byte_in     (byte_in),
        .read_ack    (read_ack),
        .complete    (complete),
        .error       (error),
        .byte_out    (byte_out),
        .scl_oe      (scl_oe),
        .sda_oe      (sda_oe),
        .scl_in      (scl_in),
        .sda_in      (sda_in)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       scl;
        logic       sda;
        logic       cmpl;
        logic       err;
        logic [7:0] bout;
    } exp_t;

    exp_t       exp_q[$];
    logic       m_err = 1'b0;
    logic [7:0] m_byte = 8'h00;

    // Expected per-cycle bus drive from the quarter tables; sb = slave line levels per slot, MSB = first slot
    task automatic push_model(input logic [1:0] instr, input logic [7:0] b, input logic ack,
                              input logic [8:0] sb, input int hold);
        logic [1:0] lv[$];
        logic [1:0] last;
        logic       d;
        exp_t       e;
        case (instr)
            2'd0: lv = '{2'b00, 2'b00, 2'b01, 2'b11};
            2'd1: lv = '{2'b11, 2'b01, 2'b01, 2'b00};
            default: begin
                for (int s = 0; s < 9; s++) begin
                    if (s == 8) d = (instr == 2'd2) && ack;
                    else        d = (instr == 2'd3) && !b[7-s];
                    lv.push_back({1'b1, d});
                    lv.push_back({1'b0, d});
                    lv.push_back({1'b0, d});
                    lv.push_back({1'b1, d});
                end
            end
        endcase
        m_err = 1'b0;
        if (instr == 2'd3) m_err = sb[0];
        if (instr == 2'd2) m_byte = sb[8:1];
        foreach (lv[q]) begin
            for (int c = 0; c < D; c++) begin
                e.scl = lv[q][1]; e.sda = lv[q][0]; e.cmpl = 1'b0; e.err = 1'b0; e.bout = 8'h00;
                exp_q.push_back(e);
            end
        end
        last = lv[lv.size()-1];
        for (int h = 0; h <= hold; h++) begin
            e.scl = last[1]; e.sda = last[0]; e.cmpl = 1'b1; e.err = m_err; e.bout = m_byte;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_cmd(input logic [1:0] instr, input logic [7:0] b, input logic ack,
                          input logic [8:0] sb, input int hold, input int st_at, input int st_len,
                          input bit use_model);
        int n, total, slot;
        @(negedge clk);
        instruction = instr; byte_in = b; read_ack = ack; enable = 1'b1;
        @(posedge clk); #1;
        n = (instr < 2'd2) ? 4*D : 36*D;
        total = n + hold + ((st_len > 0) ? STRETCH_DELAY : 0);
        if (use_model) push_model(instr, b, ack, sb, hold);
        for (int k = 0; k < total; k++) begin
            slot = k / (4*D);
            if ((instr >= 2'd2) && (slot <= 8)) slave_pull = !sb[8-slot];
            else                                slave_pull = 1'b0;
            scl_stretch = (k >= st_at) && (k < st_at + st_len);
            @(posedge clk); #1;
        end
        slave_pull = 1'b0; scl_stretch = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scl_oe", scl_oe, e.scl);
            check("sda_oe", sda_oe, e.sda);
            check("complete", complete, e.cmpl);
            if (e.cmpl) begin
                check("error", error, e.err);
                check("byte_out", byte_out, e.bout);
            end
        end
    end

    logic       p_scl = 1'b1, p_sda = 1'b1, p_cmpl = 1'b1;
    int         start_cnt = 0, stop_cnt = 0, busy_cnt = 0, last_busy = 0, acc_cnt = 0;
    logic [8:0] mon_bits = 9'h000;

    always @(negedge clk) begin : monitor
        logic scl_l, sda_l;
        scl_l = ~scl_oe & ~scl_stretch;
        sda_l = ~sda_oe & ~slave_pull;
        if (scl_l && !p_scl) mon_bits = {mon_bits[7:0], sda_l};
        if (scl_l && p_scl && p_sda && !sda_l) start_cnt++;
        if (scl_l && p_scl && !p_sda && sda_l) stop_cnt++;
        if (!complete) begin
            if (p_cmpl) begin busy_cnt = 1; acc_cnt++; end
            else busy_cnt++;
        end else if (!p_cmpl) begin
            last_busy = busy_cnt;
        end
        p_scl = scl_l; p_sda = sda_l; p_cmpl = complete;
    end

    initial begin
        int s0, a0;
        instruction = 2'd0; enable = 1'b0; byte_in = 8'h00; read_ack = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_complete", complete, 1);
        check("reset_error", error, 0);
        check("reset_byte_out", byte_out, 8'h00);
        check("reset_scl_oe", scl_oe, 0);
        check("reset_sda_oe", sda_oe, 0);

        s0 = start_cnt;
        do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, 1, 0, 0, 1'b1);
        check("start_sda_fall_scl_high", start_cnt - s0, 1);
        check("start_latency", last_busy, 16);

        do_cmd(2'd3, 8'h78, 1'b0, 9'h1FE, 1, 0, 0, 1'b1);
        check("write78_bus_bits", mon_bits, 9'h0F0);
        check("write78_latency", last_busy, 144);
        check("write78_error", error, 0);

        do_cmd(2'd3, 8'h3C, 1'b0, 9'h1FF, 1, 0, 0, 1'b1);
        check("write3c_nack_error", error, 1);
        check("write3c_complete", complete, 1);
        check("write3c_bus_bits", mon_bits, 9'h079);

        s0 = start_cnt;
        do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, 1, 0, 0, 1'b1);
        check("restart_clears_error", error, 0);
        check("restart_sda_fall", start_cnt - s0, 1);

        do_cmd(2'd2, 8'h00, 1'b0, 9'h14B, 1, 0, 0, 1'b1);
        check("read_a5_byte", byte_out, 8'hA5);
        check("read_a5_bus_bits", mon_bits, 9'h14B);

        a0 = acc_cnt;
        do_cmd(2'd2, 8'h00, 1'b1, 9'h079, 50, 0, 0, 1'b1);
        check("read_3c_byte", byte_out, 8'h3C);
        check("read_3c_master_ack", mon_bits, 9'h078);
        check("held_enable_single_cmd", acc_cnt - a0, 1);

        s0 = stop_cnt;
        do_cmd(2'd1, 8'h00, 1'b0, 9'h1FF, 1, 0, 0, 1'b1);
        check("stop_sda_rise_scl_high", stop_cnt - s0, 1);
        check("stop_latency", last_busy, 16);

        do_cmd(2'd3, 8'h78, 1'b0, 9'h1FF, 1, 52, 20, 1'b0);
        check("stretch_latency", last_busy, 144 + STRETCH_DELAY);
        check("stretch_error", error, 1);
`ifdef I2C_CLK_STRETCH_EN
        check("stretch_bus_bits", mon_bits, 9'h0F1);
`endif

        @(negedge clk);
        instruction = 2'd3; byte_in = 8'h00; read_ack = 1'b0; enable = 1'b1;
        repeat (31) @(posedge clk);
        #1;
        check("midwrite_busy", complete, 0);
        check("midwrite_scl_oe", scl_oe, 1);
        check("midwrite_sda_oe", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("rst_scl_release", scl_oe, 0);
        check("rst_sda_release", sda_oe, 0);
        check("rst_complete", complete, 1);
        check("rst_byte_out", byte_out, 8'h00);
        enable = 1'b0; m_err = 1'b0; m_byte = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, 1, 0, 0, 1'b1);
        do_cmd(2'd1, 8'h00, 1'b0, 9'h1FF, 1, 0, 0, 1'b1);
        repeat (2) @(posedge clk);
        check("model_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
